// File: rtl/sampled_addr_queue_if.sv
// Handshake bundle for sampled_addr_queue: sampled input stream, query/migration
// handshake and status. The master drives stimulus; the queue itself is the slave.
interface sampled_addr_queue_if #(
  parameter int ADDR_SIZE = 22,
  parameter int DEPTH     = 8,
  parameter int PERIOD_W  = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [ADDR_SIZE-1:0] input_addr;
  logic                 input_addr_valid;
  logic                 input_addr_ready;
  logic [PERIOD_W-1:0]  sample_period;
  logic                 query_en;
  logic                 query_ready;
  logic                 mig_addr_en;
  logic [ADDR_SIZE-1:0] mig_addr;
  logic                 mig_addr_ready;
  logic [OCC_W-1:0]     occupancy;
  logic [15:0]          drop_cnt;

  modport master (
    output input_addr, input_addr_valid, sample_period, query_en, mig_addr_ready,
    input  input_addr_ready, query_ready, mig_addr_en, mig_addr, occupancy, drop_cnt
  );

  modport slave (
    input  input_addr, input_addr_valid, sample_period, query_en, mig_addr_ready,
    output input_addr_ready, query_ready, mig_addr_en, mig_addr, occupancy, drop_cnt
  );
endinterface

// File: rtl/sampled_addr_queue.sv
// Samples one of every N valid hot addresses into a FIFO and hands them out one at a
// time on query. Optional duplicate suppression: define SAMPLED_ADDR_QUEUE_DEDUP_EN.
module sampled_addr_queue #(
  parameter int ADDR_SIZE = 22,
  parameter int DEPTH     = 8,
  parameter int PERIOD_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sampled_addr_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PERIOD_W:0]   PERIOD_ONE = {{PERIOD_W{1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] CNT_ONE    = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]    PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0]    OCC_ONE    = {{(OCC_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0]    OCC_FULL   = OCC_W'(DEPTH);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e               state_q;
  logic [ADDR_SIZE-1:0] mig_addr_q;
  logic                 mig_addr_en_q;
  logic                 query_ready_q;

  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic [15:0]          drop_q, drop_d;
  logic [ADDR_SIZE-1:0] mem_q [DEPTH];

  logic [PERIOD_W:0]    period_eff;
  logic                 sample, dup, full, pop, push, drop;

  // NOTE: every always_comb output is given a default first, so no latch is inferred.
  always_comb begin
    period_eff = (bus.sample_period == '0) ? PERIOD_ONE : {1'b0, bus.sample_period};
    sample     = bus.input_addr_valid && (({1'b0, cnt_q} + PERIOD_ONE) >= period_eff);
    full       = (count_q == OCC_FULL);
    pop        = (state_q == IDLE) && bus.query_en && (count_q != '0);
    push       = sample && !dup && (!full || pop);
    drop       = sample && !dup && full && !pop;

    cnt_d = cnt_q;
    if (bus.input_addr_valid) cnt_d = sample ? '0 : cnt_q + CNT_ONE;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase

    drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

`ifdef SAMPLED_ADDR_QUEUE_DEDUP_EN
  logic [PTR_W-1:0] offset;

  // An entry is live when its distance from the head is below the occupancy;
  // the head counts even if it is being popped this cycle.
  always_comb begin
    dup    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && (mem_q[i] == bus.input_addr)) dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // NOTE: the storage array has no reset; an entry is only read once count_q covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.input_addr;
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Query handshake: the popped head is held in mig_addr_q until the consumer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mig_addr_q    <= '0;
      mig_addr_en_q <= 1'b0;
      query_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q       <= PRESENT;
            mig_addr_q    <= mem_q[rd_ptr_q];
            mig_addr_en_q <= 1'b1;
            query_ready_q <= 1'b0;
          end
        end
        PRESENT: begin
          if (bus.mig_addr_ready) begin
            state_q       <= IDLE;
            mig_addr_en_q <= 1'b0;
            query_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.input_addr_ready = 1'b1;
  assign bus.query_ready      = query_ready_q;
  assign bus.mig_addr_en      = mig_addr_en_q;
  assign bus.mig_addr         = mig_addr_q;
  assign bus.occupancy        = count_q;
  assign bus.drop_cnt         = drop_q;
endmodule

// File: tb/tb_sampled_addr_queue.sv
// Self-checking bench for sampled_addr_queue: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a queue model.
module tb_sampled_addr_queue;
  localparam int ADDR_SIZE = 22;
  localparam int DEPTH     = 8;
  localparam int PERIOD_W  = 8;
`ifdef SAMPLED_ADDR_QUEUE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef logic [ADDR_SIZE-1:0] addr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sampled_addr_queue_if #(.ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) bus ();

  sampled_addr_queue #(.ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a plain queue plus sampling counter, drop count and handshake flag.
  addr_t       m_q[$];
  int          m_cnt     = 0;
  int unsigned m_drop    = 0;
  bit          m_present = 1'b0;
  addr_t       m_mig     = '0;

  always @(posedge clk or posedge rst) begin
    bit    do_pop, do_smp, is_dup;
    int    eff;
    addr_t head;
    if (rst) begin
      m_q.delete();
      m_cnt     = 0;
      m_drop    = 0;
      m_present = 1'b0;
      m_mig     = '0;
    end else begin
      do_pop = !m_present && (bus.query_en === 1'b1) && (m_q.size() > 0);
      do_smp = 1'b0;
      head   = '0;
      if (bus.input_addr_valid === 1'b1) begin
        eff = (bus.sample_period == 0) ? 1 : int'(bus.sample_period);
        if (m_cnt + 1 >= eff) begin
          do_smp = 1'b1;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
      is_dup = 1'b0;
      if (do_smp && DEDUP)
        foreach (m_q[i]) if (m_q[i] == bus.input_addr) is_dup = 1'b1;
      if (do_pop) head = m_q.pop_front();
      if (do_smp && !is_dup) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.input_addr);
        else if (m_drop < 32'hFFFF) m_drop++;
      end
      if (do_pop) begin
        m_present = 1'b1;
        m_mig     = head;
      end else if (m_present && bus.mig_addr_ready) begin
        m_present = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("occupancy",        32'(bus.occupancy),        32'(m_q.size()));
      check("drop_cnt",         32'(bus.drop_cnt),         m_drop);
      check("mig_addr_en",      32'(bus.mig_addr_en),      32'(m_present));
      check("query_ready",      32'(bus.query_ready),      32'(!m_present));
      check("mig_addr",         32'(bus.mig_addr),         32'(m_mig));
      check("input_addr_ready", 32'(bus.input_addr_ready), 32'd1);
    end
  end

  task automatic idle_inputs();
    bus.input_addr       = '0;
    bus.input_addr_valid = 1'b0;
    bus.query_en         = 1'b0;
    bus.mig_addr_ready   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_one(input addr_t a);
    bus.input_addr       = a;
    bus.input_addr_valid = 1'b1;
    @(negedge clk);
    bus.input_addr_valid = 1'b0;
  endtask

  task automatic query(input int hold, output addr_t got);
    bus.query_en       = 1'b1;
    bus.mig_addr_ready = 1'b0;
    @(negedge clk);
    bus.query_en = 1'b0;
    check("q_latency_en", 32'(bus.mig_addr_en), 32'd1);
    check("q_latency_qr", 32'(bus.query_ready), 32'd0);
    got = bus.mig_addr;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("q_hold_en", 32'(bus.mig_addr_en), 32'd1);
      check("q_hold_qr", 32'(bus.query_ready), 32'd0);
    end
    bus.mig_addr_ready = 1'b1;
    @(negedge clk);
    bus.mig_addr_ready = 1'b0;
    check("q_release_en", 32'(bus.mig_addr_en), 32'd0);
    check("q_release_qr", 32'(bus.query_ready), 32'd1);
  endtask

  initial begin
    addr_t got;
    idle_inputs();
    bus.sample_period = 8'd1;
    do_reset();
    check("reset_occ",  32'(bus.occupancy),   32'd0);
    check("reset_drop", 32'(bus.drop_cnt),    32'd0);
    check("reset_qr",   32'(bus.query_ready), 32'd1);

    // Every fourth valid input is sampled.
    bus.sample_period = 8'd4;
    for (int i = 0; i < 8; i++) push_one(addr_t'(32'h10 + i));
    check("p4_occ", 32'(bus.occupancy), 32'd2);
    query(0, got); check("p4_first",  32'(got), 32'h13);
    query(0, got); check("p4_second", 32'(got), 32'h17);
    bus.query_en = 1'b1;
    @(negedge clk);
    bus.query_en = 1'b0;
    check("empty_query_en", 32'(bus.mig_addr_en), 32'd0);
    check("empty_query_qr", 32'(bus.query_ready), 32'd1);

    // A zero period behaves as one.
    do_reset();
    bus.sample_period = 8'd0;
    push_one(addr_t'(32'h1));
    push_one(addr_t'(32'h2));
    check("p0_occ", 32'(bus.occupancy), 32'd2);
    query(0, got); check("p0_first",  32'(got), 32'h1);
    query(0, got); check("p0_second", 32'(got), 32'h2);

    // Consumer stalls for three cycles.
    do_reset();
    bus.sample_period = 8'd1;
    push_one(addr_t'(32'hA));
    query(3, got);
    check("stall_addr", 32'(got), 32'hA);
    check("stall_occ",  32'(bus.occupancy), 32'd0);

    // Overfill: two samples dropped, the first eight come back in order.
    do_reset();
    for (int i = 0; i < 10; i++) push_one(addr_t'(32'h100 + i));
    check("full_occ",  32'(bus.occupancy), 32'd8);
    check("full_drop", 32'(bus.drop_cnt),  32'd2);
    for (int i = 0; i < 8; i++) begin
      query(0, got);
      check("fifo_order", 32'(got), 32'h100 + i);
    end

    // Push and pop together on a full queue.
    do_reset();
    for (int i = 0; i < 8; i++) push_one(addr_t'(32'h200 + i));
    bus.input_addr       = addr_t'(32'h55);
    bus.input_addr_valid = 1'b1;
    bus.query_en         = 1'b1;
    @(negedge clk);
    bus.input_addr_valid = 1'b0;
    bus.query_en         = 1'b0;
    check("pp_occ",  32'(bus.occupancy), 32'd8);
    check("pp_drop", 32'(bus.drop_cnt),  32'd0);
    check("pp_head", 32'(bus.mig_addr),  32'h200);
    bus.mig_addr_ready = 1'b1;
    @(negedge clk);
    bus.mig_addr_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      query(0, got);
      check("pp_order", 32'(got), 32'h200 + i);
    end
    query(0, got);
    check("pp_tail", 32'(got), 32'h55);

    // Asynchronous reset while an address is presented.
    do_reset();
    for (int i = 0; i < 10; i++) push_one(addr_t'(32'h300 + i));
    for (int i = 0; i < 4; i++) query(0, got);
    bus.query_en = 1'b1;
    @(negedge clk);
    bus.query_en = 1'b0;
    check("prst_en",  32'(bus.mig_addr_en), 32'd1);
    check("prst_occ", 32'(bus.occupancy),   32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_en",   32'(bus.mig_addr_en), 32'd0);
    check("arst_occ",  32'(bus.occupancy),   32'd0);
    check("arst_drop", 32'(bus.drop_cnt),    32'd0);
    check("arst_addr", 32'(bus.mig_addr),    32'd0);
    check("arst_qr",   32'(bus.query_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Duplicate samples: suppressed only when dedup is built in.
    do_reset();
    push_one(addr_t'(32'h7));
    push_one(addr_t'(32'h7));
    push_one(addr_t'(32'h8));
    check("dup_occ",  32'(bus.occupancy), DEDUP ? 32'd2 : 32'd3);
    check("dup_drop", 32'(bus.drop_cnt),  32'd0);

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.input_addr       = addr_t'($urandom_range(0, 15));
      bus.input_addr_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.sample_period = 8'($urandom_range(0, 4));
      bus.query_en         = ($urandom_range(0, 2) == 0);
      bus.mig_addr_ready   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end

    idle_inputs();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sampled_addr_queue.md
SAMPLED_ADDR_QUEUE -- requirements
Module: sampled_addr_queue

Interface
REQ-001 Parameter ADDR_SIZE, default 22, address width in bits.
REQ-002 Parameter DEPTH, default 8, queue entries; SHALL be a power of two, at least 2.
REQ-003 Parameter PERIOD_W, default 8, width of sample_period.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 input_addr  input  ADDR_SIZE  candidate hot address.
REQ-007 input_addr_valid  input  1  input_addr is valid this cycle.
REQ-008 input_addr_ready  output  1  input accept; constant 1.
REQ-009 sample_period  input  PERIOD_W  sample one of every N valid inputs; 0 is treated as 1.
REQ-010 query_en  input  1  hot-tracker request for one migration address.
REQ-011 query_ready  output  1  queue can accept query_en.
REQ-012 mig_addr_en  output  1  mig_addr is valid.
REQ-013 mig_addr  output  ADDR_SIZE  migration address.
REQ-014 mig_addr_ready  input  1  consumer accepts mig_addr.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 drop_cnt  output  16  count of sampled addresses discarded; saturates at 0xFFFF.

Function
REQ-017 The sample counter SHALL increment on every cycle with input_addr_valid=1.
REQ-018 A valid input SHALL be sampled when counter+1 >= max(sample_period,1); on a sample, the counter SHALL return to 0. A period change therefore takes effect on the next valid input.
REQ-019 A sampled address SHALL be pushed at the tail and be visible in occupancy one cycle later.
REQ-020 A sample arriving when the queue is full and no pop occurs that cycle SHALL be discarded, and drop_cnt SHALL increment by 1.
REQ-021 Push and pop in the same cycle with the queue full SHALL both succeed, leaving occupancy unchanged.
REQ-022 Query state machine states are IDLE and PRESENT:
- IDLE: query_ready=1 and mig_addr_en=0.
- IDLE, query_en=1, occupancy>0: pop the head into the mig_addr register, set mig_addr_en=1 on the next cycle, go to PRESENT.
- IDLE, query_en=1, occupancy=0: ignored; stay in IDLE.
- PRESENT: query_ready=0; mig_addr and mig_addr_en SHALL be held stable until mig_addr_ready=1.
- PRESENT, mig_addr_ready=1: clear mig_addr_en on the next cycle and return to IDLE.
REQ-023 query_en while in PRESENT SHALL be ignored.
REQ-024 Latency from an accepted query_en to mig_addr_en=1 SHALL be exactly 1 cycle.
REQ-025 The queue SHALL be first-in-first-out, with read and write pointers wrapping modulo DEPTH.

Reset
REQ-026 While rst=1, asynchronously:
- mig_addr_en=0, mig_addr=0, occupancy=0, drop_cnt=0;
- sample counter=0, pointers=0, state=IDLE.
REQ-027 query_ready SHALL be 1 and input_addr_ready SHALL be 1 out of reset.
REQ-028 Reset asserted in PRESENT SHALL drop the pending address without requiring a handshake.

Configuration
REQ-029 Macro SAMPLED_ADDR_QUEUE_DEDUP_EN.
REQ-030 When SAMPLED_ADDR_QUEUE_DEDUP_EN is defined, a sample equal to any stored entry SHALL be discarded without incrementing drop_cnt. An entry being popped in the same cycle still counts as stored.
REQ-031 When SAMPLED_ADDR_QUEUE_DEDUP_EN is undefined, duplicate addresses SHALL be queued normally and no comparators SHALL be built.

Verification
REQ-032 sample_period=4, 8 consecutive valid inputs 0x10..0x17 -> 0x13 and 0x17 queued; occupancy=2.
REQ-033 sample_period=0, inputs 0x1, 0x2 -> both queued.
REQ-034 Queue 0xA, then query_en with mig_addr_ready held 0 for 3 cycles:
- mig_addr_en=1 one cycle after query_en, mig_addr=0xA stable and query_ready=0 throughout;
- after mig_addr_ready=1: back to IDLE, occupancy=0.
REQ-035 DEPTH=8, sample_period=1, 10 distinct inputs with no query -> occupancy=8, drop_cnt=2; 8 queries return the first 8 addresses in order.
REQ-036 Full queue, simultaneous sample 0x55 and accepted query -> head popped, 0x55 queued, occupancy=8, drop_cnt unchanged.
REQ-037 Reset during PRESENT with 3 entries -> mig_addr_en=0, occupancy=0, drop_cnt=0 immediately.
REQ-038 With SAMPLED_ADDR_QUEUE_DEDUP_EN defined, sample_period=1, inputs 0x7, 0x7, 0x8 -> occupancy=2, drop_cnt=0.
